// File: rtl/edge_detect_multi.sv
// Multi-channel trigger conditioner: synchronise, debounce, then qualify rising/falling
// edges per channel into registered pulses, sticky flags and a saturating event count.
module edge_detect_multi #(
    parameter int N_CH        = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [N_CH-1:0]     trig,
    input  logic [2*N_CH-1:0]   mode,
    input  logic [N_CH-1:0]     clr,
    input  logic                cnt_clr,
    output logic [N_CH-1:0]     pulse,
    output logic [N_CH-1:0]     level,
    output logic [N_CH-1:0]     sticky,
    output logic                any_pulse,
    output logic [CNT_W-1:0]    evt_cnt
);

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int POP_W = $clog2(N_CH + 1);
    localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [SUM_W-1:0] CNT_MAX  = SUM_W'({CNT_W{1'b1}});

    function automatic logic [POP_W-1:0] popcount(input logic [N_CH-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_CH; i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [POP_W-1:0] b);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(b);
        if (sum > CNT_MAX) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  s;
    logic [DEB_W-1:0] deb_cnt_q [N_CH];
    logic [DEB_W-1:0] deb_cnt_d [N_CH];
    logic [N_CH-1:0]  filt_q;
    logic [N_CH-1:0]  filt_d;
    logic [N_CH-1:0]  level_q;
    logic [N_CH-1:0]  pulse_q;
    logic [N_CH-1:0]  sticky_q;
    logic [N_CH-1:0]  sticky_d;
    logic             any_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  fall;
    logic [N_CH-1:0]  hit;
    logic [POP_W-1:0] hit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= trig;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Counter restarts whenever s agrees with the filtered level, so only an
    // uninterrupted run of DEB_CYCLES differing samples flips the level.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < N_CH; i++) begin
            deb_cnt_d[i] = '0;
            if (s[i] != filt_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    filt_d[i] = s[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < N_CH; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // level_q lags filt_q by one register, so the visible level and the
    // pulse derived from the filt_q/level_q difference switch on the same edge.
    assign rise = filt_q & ~level_q;
    assign fall = ~filt_q & level_q;

    always_comb begin
        hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            hit[i] = en & ((mode[2*i] & rise[i]) | (mode[2*i+1] & fall[i]));
        end
    end

    assign hit_cnt  = popcount(hit);
    assign sticky_d = (sticky_q & ~clr) | hit;
    assign cnt_d    = sat_add(cnt_clr ? '0 : cnt_q, hit_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q  <= '0;
            pulse_q  <= '0;
            sticky_q <= '0;
            any_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            level_q  <= filt_q;
            pulse_q  <= hit;
            sticky_q <= sticky_d;
            any_q    <= |hit;
            cnt_q    <= cnt_d;
        end
    end

    assign pulse     = pulse_q;
    assign level     = level_q;
    assign sticky    = sticky_q;
    assign any_pulse = any_q;
    assign evt_cnt   = cnt_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi: defaults instance plus a CNT_W=3 instance
// sharing the same stimulus to exercise counter saturation.
module tb_edge_detect_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  trig;
    logic [15:0] mode;
    logic [7:0]  clr;
    logic        cnt_clr;

    logic [7:0]  pulse, level, sticky;
    logic        any_pulse;
    logic [15:0] evt_cnt;

    logic [7:0]  pulse3, level3, sticky3;
    logic        any3;
    logic [2:0]  evt3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    edge_detect_multi dut (
        .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .mode(mode), .clr(clr),
        .cnt_clr(cnt_clr), .pulse(pulse), .level(level), .sticky(sticky),
        .any_pulse(any_pulse), .evt_cnt(evt_cnt)
    );

    edge_detect_multi #(.CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .mode(mode), .clr(clr),
        .cnt_clr(cnt_clr), .pulse(pulse3), .level(level3), .sticky(sticky3),
        .any_pulse(any3), .evt_cnt(evt3)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; trig = '0; mode = '0; clr = '0; cnt_clr = 1'b0;
        tick(2);
        chk("rst_pulse",   32'(pulse),     32'h0);
        chk("rst_level",   32'(level),     32'h0);
        chk("rst_sticky",  32'(sticky),    32'h0);
        chk("rst_any",     32'(any_pulse), 32'h0);
        chk("rst_evt",     32'(evt_cnt),   32'h0);
        chk("rst_evt3",    32'(evt3),      32'h0);
        chk("rst_level3",  32'(level3),    32'h0);
        chk("rst_sticky3", 32'(sticky3),   32'h0);
        chk("rst_any3",    32'(any3),      32'h0);
        rst_n = 1'b1;

        // 1: single rise on ch0, latency 6 edges
        en = 1'b1; mode[1:0] = 2'b01; trig[0] = 1'b1;
        tick(6);
        chk("t1_level_e5", 32'(level), 32'h00);
        chk("t1_pulse_e5", 32'(pulse), 32'h00);
        tick(1);
        chk("t1_level_e6", 32'(level),     32'h01);
        chk("t1_pulse_e6", 32'(pulse),     32'h01);
        chk("t1_any_e6",   32'(any_pulse), 32'h1);
        chk("t1_sticky",   32'(sticky),    32'h01);
        chk("t1_evt",      32'(evt_cnt),   32'd1);
        tick(1);
        chk("t1_pulse_e7", 32'(pulse),     32'h00);
        chk("t1_any_e7",   32'(any_pulse), 32'h0);
        chk("t1_evt_e7",   32'(evt_cnt),   32'd1);

        // 2: glitch rejected, then both-edge pulses 10 cycles apart
        mode[3:2] = 2'b11; cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("t2_cntclr", 32'(evt_cnt), 32'd0);
        trig[1] = 1'b1;
        tick(3);
        trig[1] = 1'b0;
        tick(10);
        chk("t2_glitch_level", 32'(level),   32'h01);
        chk("t2_glitch_pulse", 32'(pulse),   32'h00);
        chk("t2_glitch_evt",   32'(evt_cnt), 32'd0);
        trig[1] = 1'b1;
        tick(6);
        chk("t2_rise_pre", 32'(pulse), 32'h00);
        tick(1);
        chk("t2_rise_pulse", 32'(pulse),   32'h02);
        chk("t2_rise_level", 32'(level),   32'h03);
        chk("t2_rise_evt",   32'(evt_cnt), 32'd1);
        tick(3);
        trig[1] = 1'b0;
        tick(6);
        chk("t2_fall_pre",   32'(pulse), 32'h00);
        chk("t2_fall_lvpre", 32'(level), 32'h03);
        tick(1);
        chk("t2_fall_pulse",  32'(pulse),   32'h02);
        chk("t2_fall_level",  32'(level),   32'h01);
        chk("t2_fall_evt",    32'(evt_cnt), 32'd2);
        chk("t2_fall_sticky", 32'(sticky),  32'h03);
        tick(1);
        chk("t2_fall_end", 32'(pulse), 32'h00);

        // 3: fall-only ch2 vs off ch3
        mode[5:4] = 2'b10; mode[7:6] = 2'b00; trig[3:2] = 2'b11;
        tick(7);
        chk("t3_hi_level", 32'(level), 32'h0D);
        chk("t3_hi_pulse", 32'(pulse), 32'h00);
        trig[3:2] = 2'b00;
        tick(6);
        chk("t3_fall_pre", 32'(pulse), 32'h00);
        tick(1);
        chk("t3_pulse",  32'(pulse),   32'h04);
        chk("t3_level",  32'(level),   32'h01);
        chk("t3_sticky", 32'(sticky),  32'h07);
        chk("t3_evt",    32'(evt_cnt), 32'd3);
        tick(1);
        chk("t3_end", 32'(pulse), 32'h00);

        // 4: all channels rise together; CNT_W=3 instance saturates
        trig = '0; mode = 16'h5555;
        tick(7);
        chk("t4_low_level", 32'(level), 32'h00);
        chk("t4_low_pulse", 32'(pulse), 32'h00);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("t4_clr_evt",  32'(evt_cnt), 32'd0);
        chk("t4_clr_evt3", 32'(evt3),    32'd0);
        trig = 8'h1F;
        tick(7);
        chk("t4_five_pulse", 32'(pulse),   32'h1F);
        chk("t4_five_evt",   32'(evt_cnt), 32'd5);
        chk("t4_five_evt3",  32'(evt3),    32'd5);
        trig = '0;
        tick(7);
        chk("t4_drop_level", 32'(level), 32'h00);
        chk("t4_drop_pulse", 32'(pulse), 32'h00);
        trig = 8'hFF;
        tick(7);
        chk("t4_all_pulse",  32'(pulse),     32'hFF);
        chk("t4_all_pulse3", 32'(pulse3),    32'hFF);
        chk("t4_all_any",    32'(any_pulse), 32'h1);
        chk("t4_all_level",  32'(level),     32'hFF);
        chk("t4_all_evt",    32'(evt_cnt),   32'd13);
        chk("t4_sat_evt3",   32'(evt3),      32'd7);
        tick(1);
        chk("t4_end_pulse", 32'(pulse),     32'h00);
        chk("t4_end_any",   32'(any_pulse), 32'h0);
        chk("t4_end_evt",   32'(evt_cnt),   32'd13);

        // 5: sticky set-vs-clear priority, cnt_clr with simultaneous events
        clr = 8'hFF;
        tick(1);
        clr = '0;
        chk("t5_clr_all", 32'(sticky), 32'h00);
        trig[0] = 1'b0;
        tick(7);
        chk("t5_ch0_low", 32'(level), 32'hFE);
        chk("t5_ch0_nop", 32'(pulse), 32'h00);
        trig[0] = 1'b1;
        tick(6);
        clr[0] = 1'b1;
        tick(1);
        chk("t5_setwins_pulse",  32'(pulse),   32'h01);
        chk("t5_setwins_sticky", 32'(sticky),  32'h01);
        chk("t5_setwins_evt",    32'(evt_cnt), 32'd14);
        tick(1);
        clr[0] = 1'b0;
        chk("t5_clr_alone", 32'(sticky), 32'h00);
        trig[2:1] = 2'b00;
        tick(7);
        chk("t5_ch12_low", 32'(level), 32'hF9);
        trig[2:1] = 2'b11;
        tick(6);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("t5_cc_pulse",  32'(pulse),   32'h06);
        chk("t5_cc_evt",    32'(evt_cnt), 32'd2);
        chk("t5_cc_sticky", 32'(sticky),  32'h06);
        tick(1);
        chk("t5_cc_hold", 32'(evt_cnt), 32'd2);

        // 6: en gating, then reset mid-debounce with triggers held high
        trig[4] = 1'b0;
        tick(7);
        chk("t6_ch4_low", 32'(level), 32'hEF);
        en = 1'b0; trig[4] = 1'b1;
        tick(7);
        chk("t6_dis_level",  32'(level),   32'hFF);
        chk("t6_dis_pulse",  32'(pulse),   32'h00);
        chk("t6_dis_sticky", 32'(sticky),  32'h06);
        chk("t6_dis_evt",    32'(evt_cnt), 32'd2);
        en = 1'b1;
        tick(3);
        chk("t6_reen_pulse", 32'(pulse),     32'h00);
        chk("t6_reen_any",   32'(any_pulse), 32'h0);
        chk("t6_reen_evt",   32'(evt_cnt),   32'd2);
        trig[5] = 1'b0;
        tick(7);
        chk("t6_ch5_low", 32'(level), 32'hDF);
        trig[5] = 1'b1;
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("t6_arst_level",  32'(level),     32'h00);
        chk("t6_arst_pulse",  32'(pulse),     32'h00);
        chk("t6_arst_sticky", 32'(sticky),    32'h00);
        chk("t6_arst_any",    32'(any_pulse), 32'h0);
        chk("t6_arst_evt",    32'(evt_cnt),   32'd0);
        tick(2);
        chk("t6_inrst_pulse", 32'(pulse), 32'h00);
        chk("t6_inrst_level", 32'(level), 32'h00);
        rst_n = 1'b1;
        tick(6);
        chk("t6_rel_pre_pulse", 32'(pulse), 32'h00);
        chk("t6_rel_pre_level", 32'(level), 32'h00);
        tick(1);
        chk("t6_rel_pulse",  32'(pulse),     32'hFF);
        chk("t6_rel_level",  32'(level),     32'hFF);
        chk("t6_rel_sticky", 32'(sticky),    32'hFF);
        chk("t6_rel_any",    32'(any_pulse), 32'h1);
        chk("t6_rel_evt",    32'(evt_cnt),   32'd8);
        tick(1);
        chk("t6_rel_end", 32'(pulse), 32'h00);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
